pipe_exe_stage: RTL and testbench

PIPE_EXE_STAGE -- requirements
Module: pipe_exe_stage

---
 rtl/pipe_exe_pkg.sv | 24 ++
 rtl/pipe_mul_seq.sv | 80 ++++++++
 rtl/pipe_exe_stage.sv | 114 +++++++++++
 tb/tb_pipe_exe_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_exe_pkg.sv
// pipe_exe_pkg: shared definitions for the pipeline execute stage.
//   - ALUC operation codes decoded by pipe_exe_stage.
//   - State encoding of the iterative multiplier FSM in pipe_mul_seq.
// Optional feature macro used by the importing files: PIPE_EXE_MUL_EN.
package pipe_exe_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/pipe_mul_seq.sv
// pipe_mul_seq: 32-cycle shift-add multiplier, low 32 product bits only.
// Present only when PIPE_EXE_MUL_EN is defined.
// Ports:
//   clk, clr       - clock, asynchronous active-high reset
//   start          - load a/b and begin (only honoured in IDLE)
//   a, b           - operands, sampled on the start edge
//   idle/busy/done - one-hot view of the FSM state
//   product        - accumulated product, final while done is high
`ifdef PIPE_EXE_MUL_EN
module pipe_mul_seq
  import pipe_exe_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_t  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] mcand_q, mplier_q, acc_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (count_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplicand shifts left and multiplier shifts right, so each BUSY
  // cycle only ever inspects mplier_q[0].
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q  <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
          end
        end
        BUSY: begin
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 32'd0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule
`endif

// File: rtl/pipe_exe_stage.sv
// pipe_exe_stage: EX stage of a 5-stage pipeline plus the EX/MEM register.
// Optional multiplier (ALUC 1000) enabled by macro PIPE_EXE_MUL_EN; without
// it, code 1000 yields 0 and estall is tied low.
// Ports:
//   clk, clr                              - clock, async active-high reset
//   ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ea, eb, eimm,
//   epc4, ern                             - ID/EX register outputs
//   mwreg, mm2reg, mwmem, malu, mb, mrn   - EX/MEM register outputs
//   estall                                - hold PC, IF/ID and ID/EX
//   ealu                                  - combinational EX result
module pipe_exe_stage
  import pipe_exe_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [3:0]  ealuc,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] epc4,
  input  logic [4:0]  ern,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [31:0] malu,
  output logic [31:0] mb,
  output logic [4:0]  mrn,
  output logic        estall,
  output logic [31:0] ealu
);

  logic [31:0] op_a, op_b, alu_res;

  assign op_a = eshift  ? {27'b0, eimm[10:6]} : ea;
  assign op_b = ealuimm ? eimm : eb;

`ifdef PIPE_EXE_MUL_EN
  logic        mul_idle, mul_busy, mul_done, mul_start;
  logic [31:0] mul_product;

  // A mul with ewreg=0 is a bubble and never starts the multiplier.
  assign mul_start = mul_idle && (ealuc == ALUC_MUL) && ewreg;

  pipe_mul_seq u_mul (
    .clk     (clk),
    .clr     (clr),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .idle    (mul_idle),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Gated by clr so the pipeline is never held while in reset, even though
  // a mul may be sitting on the ID/EX inputs.
  assign estall = !clr && (mul_start || mul_busy);
`else
  assign estall = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (ealuc)
      ALUC_ADD: alu_res = op_a + op_b;
      ALUC_SUB: alu_res = op_a - op_b;
      ALUC_AND: alu_res = op_a & op_b;
      ALUC_OR:  alu_res = op_a | op_b;
      ALUC_XOR: alu_res = op_a ^ op_b;
      ALUC_LUI: alu_res = op_b << 16;
      ALUC_SLL: alu_res = op_b << op_a[4:0];
      ALUC_SRL: alu_res = op_b >> op_a[4:0];
      ALUC_SRA: alu_res = $signed(op_b) >>> op_a[4:0];
`ifdef PIPE_EXE_MUL_EN
      // Product is only exposed in DONE; otherwise the mul result reads 0.
      ALUC_MUL: alu_res = mul_done ? mul_product : 32'd0;
`else
      ALUC_MUL: alu_res = 32'd0;
`endif
      default:  alu_res = 32'd0;
    endcase
  end

  assign ealu = ejal ? (epc4 + 32'd4) : alu_res;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr || estall) begin
      // While stalled a bubble enters MEM; data fields are zeroed too.
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      malu   <= '0;
      mb     <= '0;
      mrn    <= '0;
    end else begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
    end
  end

endmodule

// File: tb/tb_pipe_exe_stage.sv
// tb_pipe_exe_stage: self-checking bench for pipe_exe_stage.
// Directed cases plus randomized ALU ops against a behavioural model; the
// multiplier sequence is exercised when PIPE_EXE_MUL_EN is defined.
module tb_pipe_exe_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
  logic [3:0]  ealuc;
  logic [31:0] ea, eb, eimm, epc4;
  logic [4:0]  ern;
  logic        mwreg, mm2reg, mwmem, estall;
  logic [31:0] malu, mb, ealu;
  logic [4:0]  mrn;

  int n_checks = 0;
  int n_errors = 0;

  pipe_exe_stage dut (
    .clk     (clk),
    .clr     (clr),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ewmem   (ewmem),
    .ealuimm (ealuimm),
    .eshift  (eshift),
    .ejal    (ejal),
    .ealuc   (ealuc),
    .ea      (ea),
    .eb      (eb),
    .eimm    (eimm),
    .epc4    (epc4),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mwmem   (mwmem),
    .malu    (malu),
    .mb      (mb),
    .mrn     (mrn),
    .estall  (estall),
    .ealu    (ealu)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model of the non-multiply EX result.
  function automatic logic [31:0] model_ealu();
    logic [31:0] a, b;
    a = eshift  ? {27'b0, eimm[10:6]} : ea;
    b = ealuimm ? eimm : eb;
    if (ejal) return epc4 + 32'd4;
    case (ealuc)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return b * 32'd65536;
      4'b0011: return b * (32'd1 << a[4:0]);
      4'b0111: return b / (32'd1 << a[4:0]);
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_ctrl(input logic [3:0] aluc, input logic wreg, input logic [4:0] rn);
    ealuc = aluc; ewreg = wreg; ern = rn;
    em2reg = 1'b0; ewmem = 1'b0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
  endtask

  // Inputs already applied just after a negedge; checks the combinational
  // result, one posedge, then the EX/MEM register contents.
  task automatic run_op(input string tag);
    logic [31:0] exp_alu;
    exp_alu = model_ealu();
    #1;
    check({tag, "_ealu"}, ealu, exp_alu);
    check({tag, "_estall"}, {31'b0, estall}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_malu"}, malu, exp_alu);
    check({tag, "_ctrl"}, {29'b0, mwreg, mm2reg, mwmem}, {29'b0, ewreg, em2reg, ewmem});
    check({tag, "_mb"}, mb, eb);
    check({tag, "_mrn"}, {27'b0, mrn}, {27'b0, ern});
    @(negedge clk);
  endtask

`ifdef PIPE_EXE_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rn);
    logic [31:0] exp_p;
    exp_p = a * b;
    set_ctrl(4'b1000, 1'b1, rn);
    ea = a; eb = b; eimm = $urandom; epc4 = $urandom;
    for (int i = 0; i < 33; i++) begin
      #1;
      check({tag, "_stall"}, {31'b0, estall}, 32'd1);
      @(posedge clk); #1;
      check({tag, "_bubble"}, {29'b0, mwreg, mm2reg, mwmem}, 32'd0);
      @(negedge clk);
    end
    #1;
    check({tag, "_done_stall"}, {31'b0, estall}, 32'd0);
    check({tag, "_done_ealu"}, ealu, exp_p);
    @(posedge clk); #1;
    check({tag, "_malu"}, malu, exp_p);
    check({tag, "_mwreg"}, {31'b0, mwreg}, 32'd1);
    check({tag, "_mrn"}, {27'b0, mrn}, {27'b0, rn});
    @(negedge clk);
  endtask
`endif

  initial begin
    // Reset with a would-be mul on the inputs: nothing may stall or write.
    clr = 1'b1;
    set_ctrl(4'b1000, 1'b1, 5'd9);
    ea = 32'd6; eb = 32'd7; eimm = '0; epc4 = '0;
    repeat (3) @(negedge clk);
    check("rst_estall", {31'b0, estall}, 32'd0);
    check("rst_ctrl", {29'b0, mwreg, mm2reg, mwmem}, 32'd0);
    check("rst_malu", malu, 32'd0);
    check("rst_mb", mb, 32'd0);
    check("rst_mrn", {27'b0, mrn}, 32'd0);
    clr = 1'b0;

    // Directed: add, sll/sra by shamt field, jal override.
    set_ctrl(4'b0000, 1'b1, 5'd3); ea = 32'd5; eb = 32'd7;
    run_op("add");
    check("add_value", malu, 32'd12);
    set_ctrl(4'b0011, 1'b1, 5'd4); eshift = 1'b1; eimm = 32'd4 << 6; eb = 32'h1;
    run_op("sll");
    check("sll_value", malu, 32'h10);
    set_ctrl(4'b1111, 1'b1, 5'd5); eshift = 1'b1; eimm = 32'd4 << 6; eb = 32'h8000_0000;
    run_op("sra");
    check("sra_value", malu, 32'hF800_0000);
    for (int i = 0; i < 3; i++) begin
      set_ctrl(4'($urandom_range(0, 15)), 1'b1, 5'd31); ejal = 1'b1; epc4 = 32'h100;
      ea = $urandom; eb = $urandom;
      run_op("jal");
      check("jal_value", malu, 32'h104);
    end
    set_ctrl(4'b0110, 1'b1, 5'd6); ealuimm = 1'b1; eimm = 32'h0000_ABCD;
    run_op("lui");

    // Mul with ewreg=0 is a bubble in every build.
    set_ctrl(4'b1000, 1'b0, 5'd7); ea = 32'd3; eb = 32'd4;
    run_op("mul_bubble");

    // Randomized ALU ops (mul codes forced to bubbles).
    for (int i = 0; i < 60; i++) begin
      set_ctrl(4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom));
      em2reg = 1'($urandom); ewmem = 1'($urandom);
      ealuimm = 1'($urandom); eshift = 1'($urandom); ejal = ($urandom_range(0, 7) == 0);
      ea = $urandom; eb = $urandom; eimm = $urandom; epc4 = $urandom;
      if (ealuc == 4'b1000) ewreg = 1'b0;
      run_op("rand");
    end

`ifdef PIPE_EXE_MUL_EN
    run_mul("mul_ff3", 32'hFFFF_FFFF, 32'd3, 5'd12);
    // Back-to-back muls: second starts right after DONE.
    run_mul("mul_r1", $urandom, $urandom, 5'd13);
    run_mul("mul_r2", $urandom, $urandom, 5'd14);

    // Abort a multiply at count=10 with clr.
    set_ctrl(4'b1000, 1'b1, 5'd15); ea = 32'd100; eb = 32'd200;
    repeat (11) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("abort_estall", {31'b0, estall}, 32'd0);
    check("abort_mwreg", {31'b0, mwreg}, 32'd0);
    check("abort_malu", malu, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    set_ctrl(4'b0000, 1'b1, 5'd8); ea = 32'd20; eb = 32'd22;
    run_op("abort_add");
    check("abort_add_value", malu, 32'd42);
`else
    // Multiplier absent: code 1000 is a plain zero result, no stall.
    set_ctrl(4'b1000, 1'b1, 5'd10); ea = 32'hFFFF_FFFF; eb = 32'd3;
    run_op("mul_off");
    check("mul_off_value", malu, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
